// File: rtl/bin_clause_mover.sv
// Moves one bin of clauses between the global clause RAM and the SAT clause array.
// LOAD streams RAM -> array, UPDATE streams array -> RAM, one clause per cycle.
module bin_clause_mover #(
  parameter int NUM_CLAUSES_A_BIN  = 8,
  parameter int NUM_VARS_A_BIN     = 8,
  parameter int WIDTH_CLAUSES      = NUM_VARS_A_BIN * 2,
  parameter int WIDTH_BIN_ID       = 10,
  parameter int ADDR_WIDTH_CLAUSES = 9,
  parameter int RD_LAT             = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start_i,
  input  logic                                       mode_i,
  input  logic [WIDTH_BIN_ID-1:0]                    bin_id_i,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic [$clog2(NUM_CLAUSES_A_BIN+1)-1:0]     nonempty_cnt_o,
  output logic                                       ram_re_o,
  output logic                                       ram_we_o,
  output logic [ADDR_WIDTH_CLAUSES-1:0]              ram_addr_o,
  output logic [WIDTH_CLAUSES-1:0]                   ram_din_o,
  input  logic [WIDTH_CLAUSES-1:0]                   ram_dout_i,
  output logic [NUM_CLAUSES_A_BIN-1:0]               wr_carray_o,
  output logic [WIDTH_CLAUSES-1:0]                   clause_o,
  output logic [NUM_CLAUSES_A_BIN-1:0]               rd_carray_o,
  input  logic [WIDTH_CLAUSES-1:0]                   clause_i
);

  localparam int N  = NUM_CLAUSES_A_BIN;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int AW = ADDR_WIDTH_CLAUSES;
  localparam logic [AW-1:0] N_AW = AW'(NUM_CLAUSES_A_BIN);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                    state_q, state_d;
  logic                      mode_q, mode_d;
  logic [AW-1:0]             base_q, base_d;
  logic [IW-1:0]             iss_q, iss_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [RD_LAT-1:0]         vld_q, vld_d;
  logic [RD_LAT-1:0][IW-1:0] idx_q, idx_d;

  logic                      issue;
  logic                      ret_vld;
  logic [IW-1:0]             ret_idx;
  logic [WIDTH_CLAUSES-1:0]  ret_data;

  assign issue = (state_q == ISSUE);

  // UPDATE returns after one cycle, so it taps stage 0; LOAD taps the last stage.
  assign ret_vld  = mode_q ? vld_q[0] : vld_q[RD_LAT-1];
  assign ret_idx  = mode_q ? idx_q[0] : idx_q[RD_LAT-1];
  assign ret_data = mode_q ? clause_i : ram_dout_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    vld_d[0] = issue;
    idx_d[0] = iss_q;
    for (int unsigned s = 1; s < RD_LAT; s++) begin
      vld_d[s] = vld_q[s-1] & ~mode_q;
      idx_d[s] = idx_q[s-1];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ISSUE;
      ISSUE:   if (iss_q == IW'(N - 1)) state_d = DRAIN;
      DRAIN:   if (vld_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    base_d = base_q;
    iss_d  = iss_q;
    cnt_d  = cnt_q;
    if (state_q == IDLE && start_i) begin
      mode_d = mode_i;
      base_d = AW'(bin_id_i) * N_AW;
      iss_d  = '0;
      cnt_d  = '0;
    end
    if (issue) iss_d = iss_q + IW'(1);
    if (ret_vld && ret_data != '0) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= 1'b0;
      base_q <= '0;
      iss_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      idx_q  <= '0;
    end else begin
      mode_q <= mode_d;
      base_q <= base_d;
      iss_q  <= iss_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    busy_o         = (state_q != IDLE);
    done_o         = (state_q == DONE);
    nonempty_cnt_o = cnt_q;
    ram_re_o       = issue & ~mode_q;
    ram_we_o       = 1'b0;
    ram_addr_o     = '0;
    ram_din_o      = '0;
    wr_carray_o    = '0;
    clause_o       = '0;
    rd_carray_o    = '0;
    if (issue) begin
      if (mode_q) rd_carray_o[iss_q] = 1'b1;
      else        ram_addr_o = base_q + AW'(iss_q);
    end
    if (ret_vld) begin
      if (mode_q) begin
        ram_we_o   = 1'b1;
        ram_addr_o = base_q + AW'(ret_idx);
        ram_din_o  = clause_i;
      end else begin
        wr_carray_o[ret_idx] = 1'b1;
        clause_o             = ram_dout_i;
      end
    end
  end

endmodule

// File: tb/tb_bin_clause_mover.sv
// Randomised bench for bin_clause_mover: two configurations driven in lockstep,
// each checked every cycle against a timing/contents model derived from the transfer rules.
module tb_bin_clause_mover;

  localparam int NI = 2;
  localparam int AW = 9;
  localparam int WB = 10;
  localparam int WC = 16;
  localparam int RAM_SZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic          mode_i = 1'b0;
  logic [WB-1:0] bin_id_i = '0;
  logic          do_fill = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [WC-1:0] rnd_clause();
    return ($urandom_range(0, 3) == 0) ? '0 : WC'($urandom);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int N  = (g == 0) ? 8 : 12;
    localparam int RL = (g == 0) ? 1 : 2;
    localparam int CW = $clog2(N + 1);

    logic          busy_o, done_o, ram_re_o, ram_we_o;
    logic [CW-1:0] cnt_o;
    logic [AW-1:0] ram_addr_o;
    logic [WC-1:0] ram_din_o, clause_o;
    logic [WC-1:0] ram_dout_i = '0;
    logic [WC-1:0] clause_i = '0;
    logic [N-1:0]  wr_o, rd_o;

    bin_clause_mover #(
      .NUM_CLAUSES_A_BIN (N),
      .NUM_VARS_A_BIN    (8),
      .WIDTH_CLAUSES     (WC),
      .WIDTH_BIN_ID      (WB),
      .ADDR_WIDTH_CLAUSES(AW),
      .RD_LAT            (RL)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .mode_i        (mode_i),
      .bin_id_i      (bin_id_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .nonempty_cnt_o(cnt_o),
      .ram_re_o      (ram_re_o),
      .ram_we_o      (ram_we_o),
      .ram_addr_o    (ram_addr_o),
      .ram_din_o     (ram_din_o),
      .ram_dout_i    (ram_dout_i),
      .wr_carray_o   (wr_o),
      .clause_o      (clause_o),
      .rd_carray_o   (rd_o),
      .clause_i      (clause_i)
    );

    // Environment memories and their expected twins
    logic [WC-1:0] ram     [RAM_SZ];
    logic [WC-1:0] exp_mem [RAM_SZ];
    logic [WC-1:0] arr     [N];
    logic [WC-1:0] exp_arr [N];
    logic [WC-1:0] rpipe   [3];

    // Reference transfer: accepted at cycle t0, clauses vals[] move in row order
    bit            act = 1'b0;
    bit            md = 1'b0;
    int            cyc = 0;
    int            t0 = 0;
    int            base = 0;
    logic [WC-1:0] vals [N];

    function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
    endfunction

    function automatic bit model_busy();
      int k, l;
      k = cyc - t0;
      l = md ? 1 : RL;
      return act && k >= 1 && k <= N + l + 1;
    endfunction

    function automatic string tag(input string s);
      return $sformatf("n%0d_lat%0d.%s", N, RL, s);
    endfunction

    always @(posedge clk) begin
      if (ram_we_o) ram[ram_addr_o] = ram_din_o;
      if (wr_o != '0) arr[onehot_idx(wr_o)] = clause_o;
      rpipe[2] = rpipe[1];
      rpipe[1] = rpipe[0];
      rpipe[0] = ram_re_o ? ram[ram_addr_o] : WC'($urandom);
      ram_dout_i <= rpipe[RL-1];
      clause_i   <= (rd_o != '0) ? arr[onehot_idx(rd_o)] : WC'($urandom);
      if (do_fill) begin
        for (int a = 0; a < RAM_SZ; a++) begin
          ram[a]     = rnd_clause();
          exp_mem[a] = ram[a];
        end
        for (int r = 0; r < N; r++) begin
          arr[r]     = rnd_clause();
          exp_arr[r] = arr[r];
        end
      end
      if (!rst) begin
        act = 1'b0;
      end else begin
        if (start_i && !model_busy()) begin
          act  = 1'b1;
          t0   = cyc;
          md   = mode_i;
          base = (int'(bin_id_i) * N) % RAM_SZ;
          for (int j = 0; j < N; j++) begin
            if (!md) begin
              vals[j]    = exp_mem[(base + j) % RAM_SZ];
              exp_arr[j] = vals[j];
            end else begin
              vals[j] = exp_arr[j];
              exp_mem[(base + j) % RAM_SZ] = vals[j];
            end
          end
        end
        cyc++;
      end
    end

    always @(negedge clk) begin
      int k, l;
      logic [31:0] e_busy, e_done, e_re, e_we, e_addr, e_din, e_wr, e_clause, e_rd, e_cnt;
      e_busy = 0; e_done = 0; e_re = 0; e_we = 0; e_addr = 0;
      e_din = 0; e_wr = 0; e_clause = 0; e_rd = 0; e_cnt = 0;
      if (rst && act) begin
        k = cyc - t0;
        l = md ? 1 : RL;
        e_busy = (k >= 1 && k <= N + l + 1) ? 1 : 0;
        e_done = (k == N + l + 1) ? 1 : 0;
        if (k >= 1 && k <= N) begin
          if (!md) begin
            e_re   = 1;
            e_addr = (base + k - 1) % RAM_SZ;
          end else begin
            e_rd = 32'd1 << (k - 1);
          end
        end
        if (k >= 1 + l && k <= N + l) begin
          if (!md) begin
            e_wr     = 32'd1 << (k - 1 - l);
            e_clause = 32'(vals[k - 1 - l]);
          end else begin
            e_we   = 1;
            e_addr = (base + k - 1 - l) % RAM_SZ;
            e_din  = 32'(vals[k - 1 - l]);
          end
        end
        for (int j = 0; j < N; j++) if (2 + l + j <= k && vals[j] != '0) e_cnt++;
      end
      check_val(tag("busy"),   32'(busy_o),     e_busy);
      check_val(tag("done"),   32'(done_o),     e_done);
      check_val(tag("ram_re"), 32'(ram_re_o),   e_re);
      check_val(tag("ram_we"), 32'(ram_we_o),   e_we);
      check_val(tag("addr"),   32'(ram_addr_o), e_addr);
      check_val(tag("din"),    32'(ram_din_o),  e_din);
      check_val(tag("wr_arr"), 32'(wr_o),       e_wr);
      check_val(tag("clause"), 32'(clause_o),   e_clause);
      check_val(tag("rd_arr"), 32'(rd_o),       e_rd);
      check_val(tag("cnt"),    32'(cnt_o),      e_cnt);
    end
  end

  task automatic pulse_start(input bit m, input logic [WB-1:0] b);
    @(negedge clk);
    start_i  = 1'b1;
    mode_i   = m;
    bin_id_i = b;
    @(negedge clk);
    start_i  = 1'b0;
    mode_i   = 1'($urandom);
    bin_id_i = WB'($urandom);
  endtask

  task automatic quiet(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic refill();
    @(negedge clk);
    do_fill = 1'b1;
    @(negedge clk);
    do_fill = 1'b0;
  endtask

  initial begin
    quiet(3);
    rst = 1'b1;
    refill();

    pulse_start(1'b0, WB'(0));    quiet(20);
    pulse_start(1'b0, WB'(3));    quiet(20);
    pulse_start(1'b1, WB'(2));    quiet(20);
    pulse_start(1'b0, WB'(2));    quiet(20);
    pulse_start(1'b0, WB'(1023)); quiet(20);
    pulse_start(1'b0, WB'(85));   quiet(20);
    pulse_start(1'b1, WB'(85));   quiet(20);

    // Start held high with changing mode/bin: only the IDLE-cycle sample may be taken
    @(negedge clk);
    start_i = 1'b1;
    repeat (45) begin
      mode_i   = 1'($urandom);
      bin_id_i = WB'($urandom);
      @(negedge clk);
    end
    start_i = 1'b0;
    quiet(20);

    // Asynchronous reset landing in the 4th issue cycle of a LOAD
    pulse_start(1'b0, WB'(7));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    quiet(3);
    rst = 1'b1;
    refill();
    pulse_start(1'b0, WB'(7));
    quiet(20);

    repeat (60) begin
      if ($urandom_range(0, 3) == 0) begin
        quiet(20);
        refill();
      end
      pulse_start(1'($urandom), WB'($urandom));
      quiet(int'($urandom_range(0, 20)));
    end
    quiet(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
